// File: rtl/port_hold_stage_if.sv
// +--------------------------------------------------------------------------+
// | port_hold_stage_if : requester/response signals of the four hold ports   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

interface port_hold_stage_if #(
  parameter int DATA_W = 32
);
  logic [3:0]        req1_cmd_in;
  logic [3:0]        req2_cmd_in;
  logic [3:0]        req3_cmd_in;
  logic [3:0]        req4_cmd_in;
  logic [DATA_W-1:0] req1_data_in;
  logic [DATA_W-1:0] req2_data_in;
  logic [DATA_W-1:0] req3_data_in;
  logic [DATA_W-1:0] req4_data_in;
  logic              port1_resp_done;
  logic              port2_resp_done;
  logic              port3_resp_done;
  logic              port4_resp_done;

  logic [3:0]        hold1_prio_req;
  logic [3:0]        hold2_prio_req;
  logic [3:0]        hold3_prio_req;
  logic [3:0]        hold4_prio_req;
  logic [DATA_W-1:0] hold1_data1;
  logic [DATA_W-1:0] hold2_data1;
  logic [DATA_W-1:0] hold3_data1;
  logic [DATA_W-1:0] hold4_data1;
  logic [DATA_W-1:0] hold1_data2;
  logic [DATA_W-1:0] hold2_data2;
  logic [DATA_W-1:0] hold3_data2;
  logic [DATA_W-1:0] hold4_data2;
  logic              port1_busy;
  logic              port2_busy;
  logic              port3_busy;
  logic              port4_busy;
  logic              port1_overrun;
  logic              port2_overrun;
  logic              port3_overrun;
  logic              port4_overrun;

  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    output port1_resp_done, port2_resp_done, port3_resp_done, port4_resp_done,
    input  hold1_prio_req, hold2_prio_req, hold3_prio_req, hold4_prio_req,
    input  hold1_data1, hold2_data1, hold3_data1, hold4_data1,
    input  hold1_data2, hold2_data2, hold3_data2, hold4_data2,
    input  port1_busy, port2_busy, port3_busy, port4_busy,
    input  port1_overrun, port2_overrun, port3_overrun, port4_overrun
  );

  modport slave (
    input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    input  port1_resp_done, port2_resp_done, port3_resp_done, port4_resp_done,
    output hold1_prio_req, hold2_prio_req, hold3_prio_req, hold4_prio_req,
    output hold1_data1, hold2_data1, hold3_data1, hold4_data1,
    output hold1_data2, hold2_data2, hold3_data2, hold4_data2,
    output port1_busy, port2_busy, port3_busy, port4_busy,
    output port1_overrun, port2_overrun, port3_overrun, port4_overrun
  );
endinterface

`default_nettype wire

// File: rtl/port_hold_stage.sv
// +--------------------------------------------------------------------------+
// | port_hold_stage : per-port command/operand capture ahead of calc1 prio   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module port_hold_stage #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32
) (
  input  logic              c_clk,
  input  logic              reset,
  port_hold_stage_if.slave  bus
);

  localparam int CMD_W = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OP2     = 2'd1,
    S_PRESENT = 2'd2,
    S_WAIT    = 2'd3
  } state_t;

  logic [NUM_PORTS-1:0][CMD_W-1:0]  req_cmd;
  logic [NUM_PORTS-1:0][DATA_W-1:0] req_data;
  logic [NUM_PORTS-1:0]             resp_done;
  logic [NUM_PORTS-1:0][CMD_W-1:0]  prio_req;
  logic [NUM_PORTS-1:0][DATA_W-1:0] hold_d1;
  logic [NUM_PORTS-1:0][DATA_W-1:0] hold_d2;
  logic [NUM_PORTS-1:0]             busy;
  logic [NUM_PORTS-1:0]             overrun;

  assign req_cmd   = {bus.req4_cmd_in, bus.req3_cmd_in,
                      bus.req2_cmd_in, bus.req1_cmd_in};
  assign req_data  = {bus.req4_data_in, bus.req3_data_in,
                      bus.req2_data_in, bus.req1_data_in};
  assign resp_done = {bus.port4_resp_done, bus.port3_resp_done,
                      bus.port2_resp_done, bus.port1_resp_done};

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    state_t             state_q;
    logic [CMD_W-1:0]   cmd_q;
    logic [CMD_W-1:0]   prio_q;
    logic [DATA_W-1:0]  data1_q;
    logic [DATA_W-1:0]  data2_q;
    logic               busy_q;
    logic               overrun_q;
    logic               req_seen;

    assign req_seen = |req_cmd[i];

    // prio_q and overrun_q default low so each can only pulse for one cycle
    always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
        state_q   <= S_IDLE;
        cmd_q     <= '0;
        prio_q    <= '0;
        data1_q   <= '0;
        data2_q   <= '0;
        busy_q    <= 1'b0;
        overrun_q <= 1'b0;
      end else begin
        prio_q    <= '0;
        overrun_q <= 1'b0;
        case (state_q)
          S_IDLE: begin
            if (req_seen) begin
              cmd_q   <= req_cmd[i];
              data1_q <= req_data[i];
              busy_q  <= 1'b1;
              state_q <= S_OP2;
            end
          end
          S_OP2: begin
            data2_q <= req_data[i];
            prio_q  <= cmd_q;
            state_q <= S_PRESENT;
          end
          S_PRESENT: begin
            overrun_q <= req_seen;
            state_q   <= S_WAIT;
          end
          S_WAIT: begin
            // a command arriving with resp_done is still dropped as an overrun
            overrun_q <= req_seen;
            if (resp_done[i]) begin
              cmd_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end

    assign prio_req[i] = prio_q;
    assign hold_d1[i]  = data1_q;
    assign hold_d2[i]  = data2_q;
    assign busy[i]     = busy_q;
    assign overrun[i]  = overrun_q;
  end

  assign bus.hold1_prio_req = prio_req[0];
  assign bus.hold2_prio_req = prio_req[1];
  assign bus.hold3_prio_req = prio_req[2];
  assign bus.hold4_prio_req = prio_req[3];
  assign bus.hold1_data1    = hold_d1[0];
  assign bus.hold2_data1    = hold_d1[1];
  assign bus.hold3_data1    = hold_d1[2];
  assign bus.hold4_data1    = hold_d1[3];
  assign bus.hold1_data2    = hold_d2[0];
  assign bus.hold2_data2    = hold_d2[1];
  assign bus.hold3_data2    = hold_d2[2];
  assign bus.hold4_data2    = hold_d2[3];
  assign bus.port1_busy     = busy[0];
  assign bus.port2_busy     = busy[1];
  assign bus.port3_busy     = busy[2];
  assign bus.port4_busy     = busy[3];
  assign bus.port1_overrun  = overrun[0];
  assign bus.port2_overrun  = overrun[1];
  assign bus.port3_overrun  = overrun[2];
  assign bus.port4_overrun  = overrun[3];

endmodule

`default_nettype wire

// File: doc/port_hold_stage.md
# port_hold_stage

Per-port request capture stage in front of the calc1 priority logic. For each of the four requester ports it runs a small FSM with these steps:

- Latch a command and its first operand in one cycle and the second operand in the next.
- Present the command to the priority stage as a one-cycle `holdN_prio_req` pulse.
- Hold the operands stable, and mark the port busy until the output stage reports the response delivered.

Requests arriving on a busy port are dropped and flagged.

## Interface
- `NUM_PORTS`, default 4: number of requester ports. Fixed at 4 to match the four priority inputs.
- `DATA_W`, default 32: operand width.
- `c_clk` input 1: sole clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high. Clears all state immediately.
- `reqN_cmd_in` (N=1..4) input 4: command. 0 means no request. Any nonzero value is a request.
- `reqN_data_in` (N=1..4) input `DATA_W`:
  - carries operand 1 in the command cycle;
  - carries operand 2 in the following cycle.
- `portN_resp_done` (N=1..4) input 1: one-cycle pulse from the output stage when port N's response has been delivered.
- `holdN_prio_req` (N=1..4) output 4: command presented to priority. Nonzero for exactly one cycle per accepted request.
- `holdN_data1`, `holdN_data2` (N=1..4) output `DATA_W` each: captured operands, held stable while the port is non-IDLE.
- `portN_busy` (N=1..4) output 1: high while port N cannot accept a new command.
- `portN_overrun` (N=1..4) output 1: one-cycle pulse when a nonzero command arrives while port N is busy.

## Operation
- Four identical, independent per-port FSMs. No interaction between ports.
- States, with entry conditions:
  - IDLE: entered from reset, or from WAIT after `resp_done`.
  - OP2: entered after a command is captured.
  - PRESENT: one cycle, after operand 2 is captured.
  - WAIT: after PRESENT.
- Transitions:
  - IDLE with `cmd_in` != 0: capture cmd and `data_in` (into `data1`), go to OP2.
  - OP2: capture `data_in` into `data2` unconditionally, go to PRESENT. `cmd_in` in this cycle is ignored, because it is the operand-2 cycle; no overrun.
  - PRESENT: drive `holdN_prio_req` = captured cmd, go to WAIT.
  - WAIT: stay until `resp_done` = 1, then go to IDLE and clear the captured cmd.
- `portN_busy`: high in OP2, PRESENT and WAIT; low only in IDLE.
- `portN_overrun`: pulses for one cycle in PRESENT or WAIT when `cmd_in` != 0. The command is discarded and the state is unchanged.
- `resp_done` outside WAIT is ignored, with no state change.
- `resp_done` and a nonzero `cmd_in` in the same WAIT cycle: the response is accepted (go to IDLE), the command counts as an overrun and is dropped.
- `holdN_prio_req` is 0 in every state except PRESENT. The priority stage latches the nonzero value itself, so a single pulse is sufficient.
- Operand registers load only in IDLE (`data1`) and OP2 (`data2`). They are otherwise unchanged, including after returning to IDLE.

## Timing
- Reset (asynchronous): all FSMs to IDLE. All outputs 0: `prio_req`, `data1`, `data2`, `busy`, `overrun`.
- A reset pulse mid-operation abandons the request with no `prio_req` emitted. The first command after reset is accepted normally.
- Request latency: command at cycle t, operand 2 at t+1, `prio_req` at t+2, with the port in WAIT from t+3.
- `busy` is asserted from t+1 (registered output). It deasserts the cycle after the `resp_done` cycle.
- Back-to-back: if `resp_done` is at cycle r, a new command is accepted at r+1 at the earliest.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Single request, port 1:
  - Stimulus: cmd=1 with data=0x00000005 at t, data=0x00000007 at t+1, `resp_done` at t+6.
  - Response: `hold1_prio_req`=1 only at t+2; data1=5 and data2=7 from t+2; `busy` high t+1..t+6, low at t+7.
- Overrun:
  - Stimulus: port 2 in WAIT, cmd=5 applied.
  - Response: `port2_overrun` pulses 1 cycle, `hold2_prio_req` stays 0, data unchanged.
  - Stimulus: cmd=6 applied during the OP2 cycle.
  - Response: no overrun, and 6 is never presented.
- All four ports:
  - Stimulus: cmd 1,2,5,6 applied on ports 1–4 in the same cycle t.
  - Response: all four `prio_req` pulses at t+2 with the correct commands; each port completes independently on its own `resp_done`.
- Simultaneous events and stray responses:
  - Stimulus: `resp_done` together with a new cmd in WAIT.
  - Response: port returns to IDLE, overrun pulses, the next cmd one cycle later is accepted.
  - Stimulus: `resp_done` in IDLE.
  - Response: ignored.
- Asynchronous reset:
  - Stimulus: reset asserted during the OP2 cycle, between clock edges.
  - Response: outputs clear before the next edge, no `prio_req` emitted, and a fresh request afterwards follows the nominal timing.
